// File: rtl/fft_sample_framer.sv
// Ping-pong framer: groups SAMPLES scalar samples into a (bit-reversed) parallel frame for FFT stage 0.
// Frame valid one cycle after the last accept; sample_in_ready drops only while both banks are full.
module fft_sample_framer #(
    parameter int SAMPLES = 4,
    parameter int WIDTH   = 32,
    parameter int BITREV  = 1,
    parameter int CNTW    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic [WIDTH-1:0] sample_in,
    input  logic             sample_in_valid,
    output logic             sample_in_ready,
    output logic [WIDTH-1:0] frame_out [SAMPLES-1:0],
    output logic             frame_valid,
    input  logic             frame_ready,
    output logic [CNTW-1:0]  frame_count
);
    localparam int IW = $clog2(SAMPLES);
    localparam logic [IW-1:0] LAST_IDX = IW'(SAMPLES - 1);

    logic [WIDTH-1:0] r_bank [0:1][0:SAMPLES-1];
    logic [1:0]       r_full;
    logic             r_wr_bank;
    logic             r_rd_bank;
    logic [IW-1:0]    r_wr_idx;
    logic [CNTW-1:0]  r_frame_count;

    logic             w_accept;
    logic             w_handoff;
    logic [IW-1:0]    w_slot;

    function automatic logic [IW-1:0] slot_of(input logic [IW-1:0] idx);
        logic [IW-1:0] r;
        r = idx;
        if (BITREV != 0) begin
            for (int i = 0; i < IW; i++) begin
                r[i] = idx[IW-1-i];
            end
        end
        return r;
    endfunction

    assign sample_in_ready = !r_full[r_wr_bank] && !reset;
    assign w_accept        = sample_in_valid && sample_in_ready;
    assign w_handoff       = frame_valid && frame_ready;
    assign w_slot          = slot_of(r_wr_idx);
    assign frame_valid     = r_full[r_rd_bank];
    assign frame_count     = r_frame_count;

    always_comb begin
        for (int j = 0; j < SAMPLES; j++) begin
            frame_out[j] = r_bank[r_rd_bank][j];
        end
    end

    // Handoff and completion always touch different banks, so both may fire in one cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int b = 0; b < 2; b++) begin
                for (int i = 0; i < SAMPLES; i++) begin
                    r_bank[b][i] <= '0;
                end
            end
            r_full        <= 2'b00;
            r_wr_bank     <= 1'b0;
            r_rd_bank     <= 1'b0;
            r_wr_idx      <= '0;
            r_frame_count <= '0;
        end else begin
            if (w_handoff) begin
                r_full[r_rd_bank] <= 1'b0;
                r_rd_bank         <= ~r_rd_bank;
                r_frame_count     <= r_frame_count + 1'b1;
            end
            if (flush) begin
                r_wr_idx <= '0;
            end else if (w_accept) begin
                r_bank[r_wr_bank][w_slot] <= sample_in;
                if (r_wr_idx == LAST_IDX) begin
                    r_full[r_wr_bank] <= 1'b1;
                    r_wr_bank         <= ~r_wr_bank;
                    r_wr_idx          <= '0;
                end else begin
                    r_wr_idx <= r_wr_idx + 1'b1;
                end
            end
        end
    end
endmodule
